// File: rtl/logic_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep/capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_sweep_pkg;

    localparam int N_IN  = 4;
    localparam int DEPTH = 16;
    localparam int N_OUT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_ram.sv
// 16x3 captured truth table: one write port, one registered read port.
// Latency: read data valid one cycle after rd_addr; a same-cycle write is not visible (old value).
// Backpressure: none; write and read are accepted every cycle, reset clears every entry.
module truth_table_ram
    import logic_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data
);

    logic [N_OUT-1:0] mem [DEPTH];

    // Storage and read register; reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/logic_sweep_capture.sv
// Sweeps x1..x4 through all 16 combinations, captures {y1,y2,y3} per combination, flags complement errors.
// Latency: done pulses 16*(SETTLE+1)+1 cycles after the edge that accepts start; rd_data lags rd_addr by one cycle.
// Backpressure: none; start is level-sampled and only honoured in IDLE, ignored while a sweep runs.
module logic_sweep_capture
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic             x4,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             y1inv,
    input  logic             y2inv,
    input  logic             y3inv,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N_IN-1:0]  err_idx,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data
);

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(DEPTH - 1);

    state_t          state_q;
    state_t          state_d;
    logic [N_IN-1:0] idx_q;
    logic [3:0]      cnt_q;
    logic            launch;
    logic            sample;
    logic            mismatch;

    // Downstream stimulus comes straight from the registered index, x1 is the MSB.
    assign {x1, x2, x3, x4} = idx_q;

    // Any response that equals its own complement line means the function is misbehaving.
    assign mismatch = (y1inv == y1) || (y2inv == y2) || (y3inv == y3);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        launch  = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy    = 1'b1;
                sample  = 1'b1;
                state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Index, settle counter and sticky first-error capture.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            err     <= 1'b0;
            err_idx <= '0;
        end else begin
            if (state_q == ST_SETTLE) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (sample) begin
                cnt_q <= '0;
                if (idx_q != IDX_LAST) begin
                    idx_q <= idx_q + 1'b1;
                end
                if (mismatch && !err) begin
                    err     <= 1'b1;
                    err_idx <= idx_q;
                end
            end
        end
    end

    truth_table_ram u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (sample),
        .wr_addr (idx_q),
        .wr_data ({y1, y2, y3}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_logic_sweep_capture.sv
// Directed bench for logic_sweep_capture with a behavioural logic_function and optional complement fault.
// Latency: checks done at cycle 49 after the start edge (SETTLE=2) and 1-cycle rd_data.
// Backpressure: n/a.
module tb_logic_sweep_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       x1, x2, x3, x4;
    logic       y1, y2, y3;
    logic       y1inv, y2inv, y3inv;
    logic       busy, done, err;
    logic [3:0] err_idx;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit fault  = 1'b0;

    logic [3:0] xv;
    logic [2:0] yv;

    always #5 clk = ~clk;

    // Reference logic_function: y1 = (x2&x3)|x1, y2 = x2^x4, y3 = ~(x1|x4).
    function automatic logic [2:0] golden(input logic [3:0] v);
        return {(v[2] & v[1]) | v[3], v[2] ^ v[0], ~(v[3] | v[0])};
    endfunction

    assign xv    = {x1, x2, x3, x4};
    assign yv    = golden(xv);
    assign y1    = yv[2];
    assign y2    = yv[1];
    assign y3    = yv[0];
    assign y1inv = ~yv[2];
    assign y2inv = (fault && (xv == 4'd5 || xv == 4'd9)) ? yv[1] : ~yv[1];
    assign y3inv = ~yv[0];

    logic_sweep_capture #(.SETTLE(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .x4      (x4),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .y1inv   (y1inv),
        .y2inv   (y2inv),
        .y3inv   (y3inv),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_idx (err_idx),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Entered at cycle 1 after the start edge; follows one whole sweep.
    task automatic run_sweep(input bit watch_rd4);
        int done_at  = -1;
        int done_cnt = 0;
        int busy_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (busy) busy_cnt++;
            if (c <= 48) check("x_seq", int'(xv), (c - 1) / 3);
            if (watch_rd4 && (c == 15 || c == 16)) check("rd4_old", int'(rd_data), 0);
            if (watch_rd4 && c == 17) check("rd4_new", int'(rd_data), int'(golden(4'd4)));
            if (c < 60) step();
        end
        check("done_cycle", done_at, 49);
        check("done_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, 48);
        check("x_after_done", int'(xv), 15);
    endtask

    task automatic read_all(input bit exp_golden);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            step();
            check("rd_data", int'(rd_data), exp_golden ? int'(golden(4'(a))) : 0);
        end
    endtask

    initial begin
        int done_q[$];

        rst     = 1'b1;
        start   = 1'b0;
        rd_addr = 4'd0;
        @(negedge clk);
        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_idx", int'(err_idx), 0);
        check("rst_x", int'(xv), 0);
        check("rst_rd", int'(rd_data), 0);
        rst = 1'b0;
        step();

        // Clean sweep with rd_addr=4 watched during capture.
        rd_addr = 4'd4;
        start   = 1'b1;
        cyc     = 0;
        step();
        start = 1'b0;
        run_sweep(1'b1);
        check("clean_err", int'(err), 0);
        read_all(1'b1);

        // Faulted sweep interrupted by reset at cycle 20.
        fault = 1'b1;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        repeat (19) step();
        check("mid_busy", int'(busy), 1);
        check("mid_err", int'(err), 1);
        check("mid_err_idx", int'(err_idx), 5);
        rst = 1'b1;
        step();
        check("mrst_busy", int'(busy), 0);
        check("mrst_x", int'(xv), 0);
        check("mrst_err", int'(err), 0);
        check("mrst_done", int'(done), 0);
        rst = 1'b0;
        read_all(1'b0);

        // Full faulted sweep: first error at 5, 9 ignored, every entry written.
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        run_sweep(1'b0);
        check("fault_err", int'(err), 1);
        check("fault_err_idx", int'(err_idx), 5);
        read_all(1'b1);
        check("err_hold", int'(err), 1);
        check("err_idx_hold", int'(err_idx), 5);

        // start held high: back-to-back sweeps every 50 cycles, err cleared on relaunch.
        fault = 1'b0;
        start = 1'b1;
        cyc   = 0;
        step();
        for (int c = 1; c <= 200; c++) begin
            if (done) done_q.push_back(c);
            if (c == 149) start = 1'b0;
            step();
        end
        check("held_done_count", done_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("held_done_cycle", (i < done_q.size()) ? done_q[i] : -1, 49 + 50 * i);
        end
        check("held_err", int'(err), 0);
        check("held_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
